// File: rtl/aec_pkg.sv
// Shared types, character codes and helpers for the infix expression calculator.
// Tokens are 5 bits: an operator flag plus a 4-bit operand value or operator code.
package aec_pkg;

    localparam int AEC_MAX_LEN = 16;
    localparam int AEC_W       = 7;

    typedef struct packed {
        logic       is_op;
        logic [3:0] val;
    } token_t;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_A   = 8'h61;
    localparam logic [7:0] CH_F   = 8'h66;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_LP  = 8'h28;
    localparam logic [7:0] CH_RP  = 8'h29;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_LPAR = 4'd3;
    localparam logic [3:0] OP_RPAR = 4'd4;

    typedef enum logic [2:0] {IDLE, READ, FLUSH, EVAL, OUT} state_t;

    // '(' gets the lowest level so it is never popped by an incoming operator.
    function automatic logic [1:0] prec(input logic [3:0] op);
        case (op)
            OP_MUL:         prec = 2'd2;
            OP_ADD, OP_SUB: prec = 2'd1;
            default:        prec = 2'd0;
        endcase
    endfunction

    function automatic logic is_token(input logic [7:0] ch);
        is_token = ((ch >= CH_0) && (ch <= CH_9)) || ((ch >= CH_A) && (ch <= CH_F)) ||
                   (ch == CH_ADD) || (ch == CH_SUB) || (ch == CH_MUL) ||
                   (ch == CH_LP)  || (ch == CH_RP);
    endfunction

    function automatic token_t to_token(input logic [7:0] ch);
        case (ch)
            CH_ADD:  to_token = '{is_op: 1'b1, val: OP_ADD};
            CH_SUB:  to_token = '{is_op: 1'b1, val: OP_SUB};
            CH_MUL:  to_token = '{is_op: 1'b1, val: OP_MUL};
            CH_LP:   to_token = '{is_op: 1'b1, val: OP_LPAR};
            CH_RP:   to_token = '{is_op: 1'b1, val: OP_RPAR};
            default: to_token = '{is_op: 1'b0,
                                  val: (ch >= CH_A) ? (ch[3:0] + 4'd9) : ch[3:0]};
        endcase
    endfunction

endpackage

// File: rtl/aec_if.sv
// Character-stream input and result output of the calculator.
interface aec_if #(parameter int W = 7);
    logic         ready;
    logic [7:0]   ascii_in;
    logic         valid;
    logic [W-1:0] result;

    modport master (output ready, ascii_in, input valid, result);
    modport slave  (input ready, ascii_in, output valid, result);
endinterface

// File: rtl/aec_stack.sv
// Simple LIFO; push takes priority over pop, overflow pushes and empty pops are dropped.
module aec_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [SW-1:0]    sp_r;

    // Storage write and stack pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r <= '0;
        end else if (push) begin
            if (sp_r < SW'(DEPTH)) begin
                mem_r[IW'(sp_r)] <= din;
                sp_r             <= sp_r + SW'(1);
            end
        end else if (pop && (sp_r != '0)) begin
            sp_r <= sp_r - SW'(1);
        end
    end

    assign empty = (sp_r == '0);
    assign top   = empty ? '0 : mem_r[IW'(sp_r - SW'(1))];

endmodule

// File: rtl/aec_calc.sv
// Infix expression calculator: buffers characters as they arrive, converts to postfix
// with a shunting-yard step per cycle, then evaluates the postfix one token per cycle.
module aec_calc
    import aec_pkg::*;
#(
    parameter int MAX_LEN = AEC_MAX_LEN,
    parameter int W       = AEC_W
) (
    input  logic clk,
    input  logic rst,
    aec_if.slave bus
);
    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    state_t         state_r, state_s;
    token_t         in_buf_r [MAX_LEN];
    token_t         pf_r     [MAX_LEN];
    logic [PW-1:0]  wr_r, rd_r, pf_len_r, ev_r, wr_idx_s;
    logic           done_r, have_r, have_s, valid_r;
    logic [W-1:0]   acc_r, acc_s, result_r;

    logic           accept_s, ch_ok_s, ch_eq_s;
    token_t         ch_tok_s, cur_s, ev_tok_s, pf_tok_s, op_din_s, op_top_s;
    logic           op_push_s, op_pop_s, op_empty_s, pf_wr_s, rd_inc_s, ev_inc_s;
    logic           nd_push_s, nd_pop_s, nd_empty_s, stk_clr_s;
    logic [W-1:0]   nd_din_s, nd_top_s;

    assign ch_ok_s   = is_token(bus.ascii_in);
    assign ch_eq_s   = (bus.ascii_in == CH_EQ);
    assign ch_tok_s  = to_token(bus.ascii_in);
    assign accept_s  = ((state_r == IDLE) && bus.ready) || ((state_r == READ) && !done_r);
    assign wr_idx_s  = (state_r == IDLE) ? '0 : wr_r;
    assign cur_s     = in_buf_r[IW'(rd_r)];
    assign ev_tok_s  = pf_r[IW'(ev_r)];
    assign stk_clr_s = rst || (state_r == IDLE);

    aec_stack #(.DEPTH(MAX_LEN), .WIDTH($bits(token_t))) u_op_stack (
        .clk(clk), .rst(stk_clr_s), .push(op_push_s), .pop(op_pop_s),
        .din(op_din_s), .top(op_top_s), .empty(op_empty_s)
    );

    // The operand stack holds everything below the top of stack; the top lives in acc_r.
    aec_stack #(.DEPTH(MAX_LEN), .WIDTH(W)) u_nd_stack (
        .clk(clk), .rst(stk_clr_s), .push(nd_push_s), .pop(nd_pop_s),
        .din(nd_din_s), .top(nd_top_s), .empty(nd_empty_s)
    );

    // Next state plus one conversion or evaluation step.
    always_comb begin
        state_s   = state_r;
        op_push_s = 1'b0;
        op_pop_s  = 1'b0;
        op_din_s  = cur_s;
        nd_push_s = 1'b0;
        nd_pop_s  = 1'b0;
        nd_din_s  = acc_r;
        pf_wr_s   = 1'b0;
        pf_tok_s  = op_top_s;
        rd_inc_s  = 1'b0;
        ev_inc_s  = 1'b0;
        acc_s     = acc_r;
        have_s    = have_r;
        case (state_r)
            IDLE: begin
                if (bus.ready) state_s = READ;
                else           state_s = IDLE;
            end
            READ: begin
                if (rd_r != wr_r) begin
                    if (!cur_s.is_op) begin
                        pf_wr_s  = 1'b1;
                        pf_tok_s = cur_s;
                        rd_inc_s = 1'b1;
                    end else if (cur_s.val == OP_LPAR) begin
                        op_push_s = 1'b1;
                        rd_inc_s  = 1'b1;
                    end else if (cur_s.val == OP_RPAR) begin
                        if (op_empty_s) begin
                            rd_inc_s = 1'b1;
                        end else if (op_top_s.val == OP_LPAR) begin
                            op_pop_s = 1'b1;
                            rd_inc_s = 1'b1;
                        end else begin
                            op_pop_s = 1'b1;
                            pf_wr_s  = 1'b1;
                        end
                    end else if (!op_empty_s && (prec(op_top_s.val) >= prec(cur_s.val))) begin
                        op_pop_s = 1'b1;
                        pf_wr_s  = 1'b1;
                    end else begin
                        op_push_s = 1'b1;
                        rd_inc_s  = 1'b1;
                    end
                end else if (done_r) begin
                    state_s = FLUSH;
                end else begin
                    state_s = READ;
                end
            end
            FLUSH: begin
                if (op_empty_s) begin
                    state_s = EVAL;
                end else begin
                    op_pop_s = 1'b1;
                    pf_wr_s  = (op_top_s.val != OP_LPAR);
                end
            end
            EVAL: begin
                if (ev_r == pf_len_r) begin
                    state_s = OUT;
                end else if (!ev_tok_s.is_op) begin
                    ev_inc_s  = 1'b1;
                    nd_push_s = have_r;
                    acc_s     = W'(ev_tok_s.val);
                    have_s    = 1'b1;
                end else begin
                    ev_inc_s = 1'b1;
                    nd_pop_s = 1'b1;
                    case (ev_tok_s.val)
                        OP_ADD:  acc_s = nd_top_s + acc_r;
                        OP_SUB:  acc_s = nd_top_s - acc_r;
                        OP_MUL:  acc_s = nd_top_s * acc_r;
                        default: acc_s = acc_r;
                    endcase
                    if (nd_empty_s) acc_s = acc_r;
                    else            have_s = 1'b1;
                end
            end
            OUT:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control registers, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            wr_r     <= '0;
            rd_r     <= '0;
            pf_len_r <= '0;
            ev_r     <= '0;
            done_r   <= 1'b0;
            have_r   <= 1'b0;
            acc_r    <= '0;
            valid_r  <= 1'b0;
            result_r <= '0;
        end else begin
            state_r <= state_s;
            valid_r <= (state_s == OUT);
            if (state_s == OUT) result_r <= acc_r;
            if (state_r == IDLE) begin
                rd_r     <= '0;
                pf_len_r <= '0;
                ev_r     <= '0;
                have_r   <= 1'b0;
                acc_r    <= '0;
                done_r   <= ch_eq_s;
                wr_r     <= (bus.ready && ch_ok_s) ? PW'(1) : '0;
            end else begin
                acc_r  <= acc_s;
                have_r <= have_s;
                if (rd_inc_s) rd_r <= rd_r + PW'(1);
                if (ev_inc_s) ev_r <= ev_r + PW'(1);
                if (pf_wr_s && (pf_len_r < PW'(MAX_LEN))) pf_len_r <= pf_len_r + PW'(1);
                if (accept_s) begin
                    done_r <= ch_eq_s || (wr_r == PW'(MAX_LEN));
                    if (ch_ok_s && (wr_r < PW'(MAX_LEN))) wr_r <= wr_r + PW'(1);
                end
            end
        end
    end

    // Character and postfix token storage.
    always_ff @(posedge clk) begin
        if (accept_s && ch_ok_s && (wr_idx_s < PW'(MAX_LEN))) in_buf_r[IW'(wr_idx_s)] <= ch_tok_s;
        if (pf_wr_s && (pf_len_r < PW'(MAX_LEN)))             pf_r[IW'(pf_len_r)]      <= pf_tok_s;
    end

    assign bus.valid  = valid_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_aec_calc.sv
// Directed bench for aec_calc: hand-computed expressions, latency bound, pulse counts, reset.
module tb_aec_calc;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   valid_cnt = 0;
    int   base;

    always #5 clk = ~clk;

    aec_if #(.W(7)) bus ();

    aec_calc #(.MAX_LEN(16), .W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

    always @(negedge clk) if (bus.valid === 1'b1) valid_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.ready    = (i == 0);
            bus.ascii_in = s[i];
        end
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int exp);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 200) begin
            if (n > 0) @(negedge clk);
            n++;
            if (bus.valid === 1'b1) seen = 1'b1;
        end
        check({tag, " latency"}, int'(seen && (n <= 48)), 1);
        check({tag, " result"}, int'(bus.result), exp);
    endtask

    task automatic run(input string s, input int exp);
        base = valid_cnt;
        send(s);
        expect_result(s, exp);
        repeat (3) @(negedge clk);
        check({s, " pulses"}, valid_cnt - base, 1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.ready    = 1'b0;
        bus.ascii_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset valid", int'(bus.valid), 0);
        check("reset result", int'(bus.result), 0);
        rst = 1'b0;

        run("3+4=", 7);
        run("2+3*4=", 14);
        run("(2+3)*4=", 20);
        run("f*f-a=", 87);
        run("((1+2)*(3+4))-5=", 16);
        run("7=", 7);
        run("5-9=", 124);
        run("2 + 3=", 5);

        base = valid_cnt;
        send("9-2*3=");
        expect_result("b2b first", 3);
        send("a=");
        expect_result("b2b second", 10);
        repeat (3) @(negedge clk);
        check("b2b pulses", valid_cnt - base, 2);

        base = valid_cnt;
        @(negedge clk);
        bus.ready = 1'b1; bus.ascii_in = "1";
        @(negedge clk);
        bus.ready = 1'b0; bus.ascii_in = "+";
        @(negedge clk);
        bus.ascii_in = "(";
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("valid in reset", int'(bus.valid), 0);
        end
        check("result after reset", int'(bus.result), 0);
        rst = 1'b0;
        send("1+1=");
        expect_result("after reset", 2);
        repeat (3) @(negedge clk);
        check("after reset pulses", valid_cnt - base, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
